store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Write-side counterpart of the load-path sign/zero extension in the MEM stage of the five-stage MIPS datapath.
- Takes SW/SH/SB requests from the EX/MEM register and narrows the register value to the addressed byte lanes.
- Data memory is word-wide with no byte enables, so SH/SB use a read-modify-write sequence.
- Stalls the pipeline through a valid/ready handshake while a sequence is in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- RD_LAT, 1, data-memory read latency in cycles. Only the value 1 is supported; any other value is a synthesis-time error.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  unit can accept a request; the pipeline stalls while st_valid=1 and st_ready=0.
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  rt register value; the low byte or low halfword is the payload for SB/SH.
- st_done  out  1  one-cycle pulse in the cycle the memory write is issued.
- st_err  out  1  one-cycle pulse for a misaligned or illegal request; no write is issued.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_rd_en  out  1  read strobe.
- mem_rd_data  in  32  read data, valid RD_LAT cycles after mem_rd_en.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  32  full word to write.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset state: state=IDLE. st_ready, st_done, st_err, mem_rd_en, mem_wr_en all 0; mem_addr and mem_wr_data 0.
- st_ready is 1 only in IDLE with Reset=0.
- Accept: occurs when st_valid & st_ready at a rising edge. On accept, latch size, addr, data.
- Alignment check at accept:
  - Halfword with addr[0]=1 -> misaligned.
  - Word with addr[1:0]!=0 -> misaligned.
  - size=11 -> illegal.
  - Misaligned or illegal -> go to ERR.
- Byte lanes are big-endian. Offset 0 maps to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0]. A halfword at offset 0 maps to [31:16]; at offset 2 it maps to [15:0].
- FSM states: IDLE, RD, MERGE, WR, ERR.
  - IDLE -> WR on an accepted legal word request.
  - IDLE -> RD on an accepted legal byte or halfword request.
  - IDLE -> ERR on a misaligned or illegal request.
  - RD: mem_rd_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}. Next state MERGE.
  - MERGE: capture mem_rd_data and replace only the addressed lanes with the payload. Untouched lanes are preserved bit-exact. Result goes into the merge register. Next state WR.
  - WR: mem_wr_en=1, st_done=1, mem_addr as above. mem_wr_data is the merge register (sub-word) or latched data (word). Next state IDLE.
  - ERR: st_err=1, all memory strobes 0. Next state IDLE.
- Latency from accept edge T:
  - Word: write at T+1, st_ready=1 at T+2.
  - Sub-word: rd_en at T+1, merge at T+2, write and done at T+3, ready at T+4.
  - Error: st_err at T+1, ready at T+2.
- Exclusivity: mem_rd_en and mem_wr_en are never both 1. st_done and st_err are never both 1.
- Payload width: payload bits above the store width are ignored; no sign or zero extension is applied on the write side.
- Input stability: st_* inputs outside the accept cycle are ignored, so the upstream stage may change them freely while stalled.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after WR or ERR. There is no bypass; a store does not observe its own pending merge.
- Reset mid-sequence: returns to IDLE on the next edge. An in-flight write is dropped; no mem_wr_en, st_done or st_err pulse occurs after the reset edge. A read already issued is discarded.
- Reset priority: Reset has priority over st_valid in the same cycle.

Decomposition:
- Shared package (mem_pkg):
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum.
  - Lane-select constant for big-endian offsets.
- Sub-module store_lane_merge (combinational): inputs old word, payload, size, offset[1:0]; output merged word.
  - Used in MERGE.
  - Reusable by the future load path as its lane extractor reference.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF -> at T+1: mem_wr_en=1, mem_addr=0x100, mem_wr_data=0xDEADBEEF, st_done=1. mem_rd_en never asserted.
- SB, addr 0x203, data 0x000000AB, memory holds 0x11223344 -> rd at T+1; at T+3: wr_data=0x112233AB, mem_addr=0x200.
- SH, addr 0x200, data 0xFFFF5A5A, memory holds 0x11223344 -> wr_data=0x5A5A3344. SB at offset 1 with data 0x7F and the same memory -> 0x117F3344.
- SH at 0x201; SW at 0x102; size=11 -> st_err pulse at T+1, no mem_rd_en or mem_wr_en, st_ready=1 at T+2.
- Reset asserted in MERGE cycle of an SB -> no write is issued, st_ready=1 in the cycle after Reset deasserts, outputs at reset values.
- Back-to-back SB then SW held on st_valid -> SW accepted in the IDLE cycle after the SB write. Exactly two writes in order; st_ready low for 3 cycles, then 1.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared store-path encodings, FSM states and big-endian lane helpers
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_ERR
  } state_e;

  localparam int LANE_W = 8;

  // Big-endian: byte offset 0 is the most significant lane, so lsb = (3 - off) * 8.
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - replaces the addressed big-endian lanes of a word with a store payload
module store_lane_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] payload,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);
  import mem_pkg::*;

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[lane_lsb(offset) +: LANE_W]     = payload[LANE_W-1:0];
      // Halfword lanes start at offset 0 or 2; the low lane of the pair gives the lsb.
      SZ_HALF: merged[lane_lsb({offset[1], 1'b1}) +: 2*LANE_W] = payload[2*LANE_W-1:0];
      default: merged = payload;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - MEM-stage store narrowing with read-modify-write for SB/SH
module store_merge_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);
  import mem_pkg::*;

  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("store_merge_unit supports RD_LAT == 1 only");
  end

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       merged;

  store_lane_merge u_merge (
    .old_word (mem_rd_data),
    .payload  (data_q),
    .size     (size_q),
    .offset   (off_q),
    .merged   (merged)
  );

  assign st_ready = (state_q == S_IDLE) && !Reset;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    off_d     = off_q;
    data_d    = data_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st_valid && st_ready) begin
          size_d = st_size;
          off_d  = st_addr[1:0];
          data_d = st_data;
          addr_d = {st_addr[ADDR_W-1:2], 2'b00};
          if (req_bad(st_size, st_addr[1:0])) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (st_size == SZ_WORD) begin
            state_d   = S_WR;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            wr_data_d = st_data;
          end else begin
            state_d = S_RD;
            rd_en_d = 1'b1;
          end
        end
      end
      S_RD: state_d = S_MERGE;
      // Read data arrives this cycle; the merge register doubles as the write data flop.
      S_MERGE: begin
        state_d   = S_WR;
        wr_data_d = merged;
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
      end
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      size_q    <= '0;
      off_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      off_q     <= off_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign st_done     = done_q;
  assign st_err      = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - scoreboard bench for store_merge_unit against a word-memory model
module tb_store_merge_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_done;
  logic        st_err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  always #5 Clk = ~Clk;

  store_merge_unit #(.ADDR_W(32), .RD_LAT(1)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_done     (st_done),
    .st_err      (st_err),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  typedef struct {
    bit          is_err;
    bit          sub;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] dut_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          orphan_rd = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    if (mem_rd_en) mem_rd_data <= dut_mem[mem_addr[9:2]];
    if (mem_wr_en) dut_mem[mem_addr[9:2]] = mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] d);
    int          nbytes;
    int          sh;
    logic [31:0] mask;
    if (sz == 2'd2) return d;
    nbytes = 1 << sz;
    sh     = 8 * (4 - int'(off) - nbytes);
    mask   = ((32'd1 << (8 * nbytes)) - 32'd1) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (mem_rd_en || mem_wr_en) check("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
    if (st_done || st_err) check("done_err_exclusive", 32'(st_done & st_err), 32'd0);
    if (st_done || mem_wr_en) check("done_with_write", 32'(st_done), 32'(mem_wr_en));
    if (mem_rd_en) begin
      if (orphan_rd) begin
        check("reset_test_rd_addr", mem_addr, 32'h200);
        orphan_rd = 0;
      end else if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: addr %h with no request pending", mem_addr);
      end else begin
        check("rd_for_subword", 32'(mem_rd_en), 32'(q[0].sub));
        check("rd_addr", mem_addr, q[0].addr);
        check("rd_cycle", 32'(cyc), 32'(q[0].cyc - 2));
      end
    end
    if (mem_wr_en || st_err) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: wr_en %b err %b addr %h data %h", mem_wr_en, st_err, mem_addr, mem_wr_data);
      end else begin
        e = q.pop_front();
        check("out_is_err", 32'(st_err), 32'(e.is_err));
        check("out_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_err) begin
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wr_data, e.data);
        end
      end
    end
  end

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    dut_mem[a[9:2]] = v;
    ref_mem[a[9:2]] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // exp_stall < 0 means the stall length is not checked for this request.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input bit use_c, input logic [31:0] cval, input int exp_stall);
    exp_t e;
    int   stall;
    bit   bad;
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
    stall    = 0;
    @(negedge Clk);
    while (!st_ready && stall < 20) begin
      stall++;
      @(negedge Clk);
    end
    if (!st_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: st_ready %b after %0d cycles, required 1", st_ready, stall);
      st_valid = 1'b0;
      return;
    end
    if (exp_stall >= 0) check("stall_cycles", 32'(stall), 32'(exp_stall));
    bad      = (sz == 2'b11) || ((a % (32'd1 << sz)) != 0);
    e.is_err = bad;
    e.sub    = !bad && (sz != 2'b10);
    e.addr   = a & ~32'h3;
    e.cyc    = cyc + 1 + (e.sub ? 2 : 0);
    e.data   = use_c ? cval : model_merge(ref_mem[a[9:2]], sz, a[1:0], d);
    if (!bad) ref_mem[a[9:2]] = e.data;
    q.push_back(e);
    @(posedge Clk);
    #1;
    st_valid = 1'b0;
    st_size  = 2'($urandom);
    st_addr  = $urandom;
    st_data  = $urandom;
  endtask

  initial begin
    bit prev_sub;
    bit b2b;
    int w;
    logic [1:0]  rs;
    logic [31:0] ra;
    for (int i = 0; i < 256; i++) begin
      dut_mem[i] = $urandom;
      ref_mem[i] = dut_mem[i];
    end
    Reset    = 1'b1;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_ready", 32'(st_ready), 32'd0);
    check("reset_done", 32'(st_done), 32'd0);
    check("reset_err", 32'(st_err), 32'd0);
    check("reset_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset_wr_en", 32'(mem_wr_en), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wr_data", mem_wr_data, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(st_ready), 32'd1);
    idle(1);

    set_word(32'h200, 32'h11223344);
    issue(2'b10, 32'h100, 32'hDEADBEEF, 1, 32'hDEADBEEF, -1);
    issue(2'b00, 32'h203, 32'h000000AB, 1, 32'h112233AB, 1);
    idle(4);
    set_word(32'h200, 32'h11223344);
    issue(2'b01, 32'h200, 32'hFFFF5A5A, 1, 32'h5A5A3344, -1);
    idle(4);
    set_word(32'h200, 32'h11223344);
    issue(2'b00, 32'h201, 32'h0000007F, 1, 32'h117F3344, -1);
    issue(2'b01, 32'h201, 32'h00001234, 1, 32'h0, 3);
    issue(2'b10, 32'h102, 32'h00005678, 1, 32'h0, 1);
    issue(2'b11, 32'h100, 32'h9ABC0000, 1, 32'h0, 1);
    issue(2'b10, 32'h104, 32'h12345678, 1, 32'h12345678, 1);
    idle(4);
    set_word(32'h200, 32'h11223344);
    issue(2'b00, 32'h202, 32'hFFFFFFC3, 1, 32'h1122C344, -1);
    issue(2'b10, 32'h200, 32'hCAFEF00D, 1, 32'hCAFEF00D, 3);
    idle(4);

    // Reset while an SB sits in MERGE: the write must be dropped.
    set_word(32'h200, 32'h11223344);
    orphan_rd = 1;
    st_valid  = 1'b1;
    st_size   = 2'b00;
    st_addr   = 32'h203;
    st_data   = 32'h000000AB;
    @(negedge Clk);
    check("rst_test_ready", 32'(st_ready), 32'd1);
    @(posedge Clk);
    #1;
    st_valid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mid_done", 32'(st_done), 32'd0);
    check("rst_mid_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    check("rst_mid_wr_data", mem_wr_data, 32'd0);
    check("rst_mid_ready", 32'(st_ready), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(st_ready), 32'd1);
    check("rst_read_seen", 32'(orphan_rd), 32'd0);
    idle(4);
    check("rst_mem_untouched", dut_mem[8'h80], 32'h11223344);

    prev_sub = 0;
    for (int n = 0; n < 150; n++) begin
      b2b = 1'($urandom_range(0, 1));
      if (!b2b || n == 0) idle($urandom_range(1, 4));
      rs = 2'($urandom_range(0, 3));
      ra = 32'h100 + 32'($urandom_range(0, 63));
      issue(rs, ra, $urandom, 0, 32'h0, (b2b && n > 0) ? (prev_sub ? 3 : 1) : -1);
      prev_sub = (rs == 2'b00) || (rs == 2'b01 && ra[0] == 1'b0);
    end

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge Clk);
      w++;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
